// File: rtl/icap_pkg.sv
// icap_pkg: state encoding, lane geometry and ICAP pin levels shared by the ICAP read/write paths.
package icap_pkg;
    localparam int ICAP_WORD_W = 32;
    localparam int LANES = 8;
    localparam int LANE_W = $clog2(LANES);
    localparam logic CSIB_ASSERT = 1'b0;
    localparam logic CSIB_DEASSERT = 1'b1;
    localparam logic RDWRB_READ = 1'b1;
    localparam logic RDWRB_WRITE = 1'b0;
    typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_READ, ST_FLUSH, ST_DRAIN} state_t;
endpackage

// File: rtl/icap_readback_packer_if.sv
// icap_readback_packer_if: ICAP readback pins and downstream FIFO write port.
interface icap_readback_packer_if #(parameter int DATA_SIZE = 256);
    logic [icap_pkg::ICAP_WORD_W-1:0] icap_o;
    logic icap_busy;
    logic icap_csib;
    logic icap_rdwrb;
    logic fifo_full;
    logic fifo_write_en;
    logic [DATA_SIZE-1:0] fifo_data;
    modport master(input icap_o, icap_busy, fifo_full, output icap_csib, icap_rdwrb, fifo_write_en, fifo_data);
    modport slave(output icap_o, icap_busy, fifo_full, input icap_csib, icap_rdwrb, fifo_write_en, fifo_data);
endinterface

// File: rtl/icap_word_packer.sv
// icap_word_packer: packs 32-bit captures into 256-bit words and holds them in a FIFO output register.
module icap_word_packer import icap_pkg::*; #(
    parameter int DATA_SIZE = 256
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   capture,
    input  logic                   flush,
    input  logic                   fifo_full,
    input  logic [ICAP_WORD_W-1:0] din,
    output logic [LANE_W-1:0]      lane,
    output logic                   out_valid,
    output logic                   fifo_write_en,
    output logic [DATA_SIZE-1:0]   fifo_data
);
    logic [LANES-1:0][ICAP_WORD_W-1:0] pack;
    logic last;
    logic load;
    assign fifo_write_en = out_valid & ~fifo_full;
    assign last = capture && lane == LANE_W'(LANES - 1);
    assign load = last | flush;
    // The FSM only loads while the output register is empty or draining, so a load never overwrites unwritten data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lane      <= '0;
            pack      <= '0;
            fifo_data <= '0;
            out_valid <= 1'b0;
        end else begin
            if (capture) begin
                lane       <= lane + 1'b1;
                pack[lane] <= din;
            end
            if (flush) lane <= '0;
            if (load) begin
                pack      <= '0;
                fifo_data <= last ? {din, pack[LANES-2:0]} : pack;
            end
            out_valid <= load | (out_valid & ~fifo_write_en);
        end
    end
endmodule

// File: rtl/icap_readback_packer.sv
// icap_readback_packer: drives ICAP in read mode for a programmed word count and streams packed
// 256-bit words into the readback FIFO.
module icap_readback_packer import icap_pkg::*; #(
    parameter int DATA_SIZE = 256,
    parameter int COUNT_W = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [COUNT_W-1:0]         word_count,
    icap_readback_packer_if.master     bus,
    output logic                       busy,
    output logic                       done
);
    state_t state, state_n;
    logic [COUNT_W-1:0] remaining, remaining_n;
    logic [LANE_W-1:0] lane;
    logic zero_done;
    logic out_valid;
    logic capture;
    logic flush;
    logic stall;
    logic csib;
    logic rdwrb;
    icap_word_packer #(.DATA_SIZE(DATA_SIZE)) u_packer (
        .clock         (clock),
        .reset_n       (reset_n),
        .capture       (capture),
        .flush         (flush),
        .fifo_full     (bus.fifo_full),
        .din           (bus.icap_o),
        .lane          (lane),
        .out_valid     (out_valid),
        .fifo_write_en (bus.fifo_write_en),
        .fifo_data     (bus.fifo_data)
    );
    // Hold off the 8th word while the previous packed word still waits for the FIFO.
    assign stall = out_valid && lane == LANE_W'(LANES - 1);
    assign busy = state != ST_IDLE;
    assign bus.icap_csib = csib;
    assign bus.icap_rdwrb = rdwrb;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            remaining <= '0;
            zero_done <= 1'b0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            zero_done <= state == ST_IDLE && start && word_count == '0;
        end
    end
    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        csib        = CSIB_DEASSERT;
        rdwrb       = RDWRB_READ;
        capture     = 1'b0;
        flush       = 1'b0;
        done        = zero_done;
        case (state)
            ST_IDLE: begin
                rdwrb = RDWRB_WRITE;
                if (start && word_count != '0) begin
                    state_n     = ST_SETUP;
                    remaining_n = word_count;
                end
            end
            ST_SETUP: state_n = ST_READ;
            ST_READ: begin
                csib    = (remaining != '0 && !stall) ? CSIB_ASSERT : CSIB_DEASSERT;
                capture = csib == CSIB_ASSERT && !bus.icap_busy;
                if (capture) begin
                    remaining_n = remaining - 1'b1;
                    if (remaining == COUNT_W'(1))
                        state_n = (lane == LANE_W'(LANES - 1)) ? ST_DRAIN : ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!out_valid) begin
                    flush   = 1'b1;
                    state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!out_valid) begin
                    done    = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_icap_readback_packer.sv
// tb_icap_readback_packer: ICAP source model plus word-grouping scoreboard for the readback packer.
module tb_icap_readback_packer;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic [15:0] word_count = '0;
    logic busy;
    logic done;
    int compared = 0;
    int mismatched = 0;

    typedef struct {
        int n;
        bit seq;
        int busy_pct;
        int full_pct;
        int hold;
        int exp_writes;
    } vec_t;
    vec_t vecs[10];

    icap_readback_packer_if #(.DATA_SIZE(256)) bus();

    icap_readback_packer #(.DATA_SIZE(256), .COUNT_W(16)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .word_count (word_count),
        .bus        (bus),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // busy_pct 101 means icap_busy toggles every cycle; hold>0 keeps fifo_full high until that cycle.
    task automatic run(input int n, input bit seq, input int busy_pct, input int full_pct,
                       input int hold, input int exp_writes, input string tag);
        logic [31:0] words[$];
        logic [255:0] exp_q[$];
        logic [255:0] w;
        logic prev_rdwrb;
        bit b;
        bit f;
        int idx = 0;
        int nwr = 0;
        int first_low = -1;
        int low_cnt = 0;
        int stall_caps = -1;
        int last_wr = -1;
        int done_cyc = -1;
        int perr = 0;
        for (int i = 0; i < n; i++) words.push_back(seq ? 32'(i) : $urandom);
        for (int g = 0; g * 8 < n; g++) begin
            w = '0;
            for (int l = 0; l < 8; l++)
                if (g * 8 + l < n) w[l*32 +: 32] = words[g*8+l];
            exp_q.push_back(w);
        end
        @(negedge clock);
        start = 1'b1;
        word_count = 16'(n);
        bus.icap_busy = 1'b1;
        bus.fifo_full = 1'b0;
        @(negedge clock);
        start = 1'b0;
        word_count = 16'($urandom);
        prev_rdwrb = bus.icap_rdwrb;
        for (int cyc = 1; cyc < 3000 && done_cyc < 0; cyc++) begin
            if (cyc > 1) @(negedge clock);
            start = (cyc == 5);
            b = (busy_pct == 101) ? cyc[0] : ($urandom_range(99) < busy_pct);
            f = (hold > 0) ? (cyc < hold) : ($urandom_range(99) < full_pct);
            bus.icap_busy = b;
            bus.fifo_full = f;
            bus.icap_o = (idx < n) ? words[idx] : $urandom;
            #1;
            if (bus.icap_csib === 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = cyc;
                if (!b) idx++;
                if (bus.icap_rdwrb !== 1'b1) perr++;
            end
            if (bus.icap_rdwrb !== prev_rdwrb && bus.icap_csib !== 1'b1) perr++;
            prev_rdwrb = bus.icap_rdwrb;
            if (bus.fifo_write_en === 1'b1) begin
                if (f) perr++;
                if (exp_q.size() > 0) chk({tag, "_data"}, bus.fifo_data, exp_q.pop_front());
                else perr++;
                nwr++;
                last_wr = cyc;
            end
            if (cyc == hold - 1) stall_caps = idx;
            if (done === 1'b1) done_cyc = cyc;
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 256'(done_cyc >= 0), 256'(1));
        chk({tag, "_captures"}, 256'(idx), 256'(n));
        chk({tag, "_writes"}, 256'(nwr), 256'(exp_writes));
        chk({tag, "_protocol"}, 256'(perr), 256'(0));
        if (n > 0) begin
            chk({tag, "_start_to_csib"}, 256'(first_low), 256'(2));
            chk({tag, "_write_to_done"}, 256'(done_cyc - last_wr), 256'(1));
        end else begin
            chk({tag, "_zero_done_lat"}, 256'(done_cyc), 256'(1));
            chk({tag, "_zero_csib_low"}, 256'(low_cnt), 256'(0));
        end
        if (n > 0 && busy_pct == 0 && full_pct == 0 && hold == 0)
            chk({tag, "_csib_low_cycles"}, 256'(low_cnt), 256'(n));
        if (hold > 0) chk({tag, "_stall_caps"}, 256'(stall_caps), 256'(n < 15 ? n : 15));
        @(negedge clock);
        #1;
        chk({tag, "_idle_after_done"}, 256'(busy), 256'(0));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_csib"}, 256'(bus.icap_csib), 256'(1));
        chk({tag, "_rdwrb"}, 256'(bus.icap_rdwrb), 256'(0));
        chk({tag, "_wen"}, 256'(bus.fifo_write_en), 256'(0));
        chk({tag, "_data"}, bus.fifo_data, 256'(0));
        chk({tag, "_busy"}, 256'(busy), 256'(0));
        chk({tag, "_done"}, 256'(done), 256'(0));
    endtask

    initial begin
        int n;
        int bad;
        vecs = '{
            '{8,  1'b1, 0,   0,  0,  1},
            '{3,  1'b0, 0,   0,  0,  1},
            '{16, 1'b0, 0,   0,  40, 2},
            '{8,  1'b1, 101, 0,  0,  1},
            '{0,  1'b0, 0,   0,  0,  0},
            '{1,  1'b0, 0,   0,  0,  1},
            '{13, 1'b0, 30,  30, 0,  2},
            '{40, 1'b0, 20,  50, 0,  5},
            '{9,  1'b0, 60,  10, 0,  2},
            '{64, 1'b0, 10,  20, 0,  8}
        };
        bus.icap_o = '0;
        bus.icap_busy = 1'b1;
        bus.fifo_full = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_values("por");
        reset_n = 1'b1;
        foreach (vecs[i])
            run(vecs[i].n, vecs[i].seq, vecs[i].busy_pct, vecs[i].full_pct, vecs[i].hold,
                vecs[i].exp_writes, $sformatf("vec%0d", i));

        // Abort a read halfway through its first group.
        @(negedge clock);
        start = 1'b1;
        word_count = 16'd8;
        bus.icap_busy = 1'b0;
        bus.fifo_full = 1'b0;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        #2 reset_n = 1'b0;
        #1 check_reset_values("midreset");
        @(negedge clock);
        reset_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            #1;
            if (bus.fifo_write_en !== 1'b0 || bus.icap_csib !== 1'b1) bad++;
        end
        chk("midreset_quiet", 256'(bad), 256'(0));
        run(8, 1'b1, 0, 0, 0, 1, "post_reset");

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(50, 1);
            run(n, 1'b0, $urandom_range(50), $urandom_range(50), 0, (n + 7) / 8, $sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/icap_readback_packer.md
# icap_readback_packer

Readback-side companion to the ICAP write path. On a start command it drives the ICAP primitive in read mode and collects a programmed number of 32-bit readback words. It packs each group of eight words into one 256-bit word and pushes the result into a downstream readback FIFO. It sits between the ICAP primitive's O/BUSY outputs and the host-facing readback FIFO, and uses the same 256-bit lane ordering as the configuration write path.

## Interface
- DATA_SIZE, 256: FIFO word width; fixed at 8 × 32. Other values are unsupported.
- COUNT_W, 16: width of the word-count field.

Ports:
- clock  in  1  single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- word_count  in  COUNT_W  number of 32-bit words to read; sampled with start
- icap_o  in  32  ICAP readback data
- icap_busy  in  1  ICAP BUSY; data is valid when low
- icap_csib  out  1  ICAP chip-select, active low
- icap_rdwrb  out  1  ICAP direction: 1 = read, 0 = write
- fifo_full  in  1  downstream FIFO full
- fifo_write_en  out  1  FIFO write strobe, active high
- fifo_data  out  DATA_SIZE  packed readback word
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the last packed word has been written

## Operation
States:
- **IDLE**
  - csib=1, rdwrb=0.
  - start with word_count≠0 → SETUP; load remaining←word_count, lane←0.
  - start with word_count=0 → one-cycle done pulse, stay in IDLE.
- **SETUP** (exactly 1 cycle)
  - csib=1, rdwrb=1. RDWRB changes only while CSIB is deasserted.
  - → READ.
- **READ**
  - csib=0 iff remaining≠0 and not (out_valid and lane=7). Otherwise csib=1 (stall).
  - Capture condition: icap_csib=0 and icap_busy=0 in the same cycle. On capture: pack[lane]←icap_o (lane 0 → bits [31:0], lane 7 → [255:224]); lane←lane+1 with 3-bit wrap; remaining←remaining−1.
  - Capture into lane 7 → transfer the packed word to the output register, set out_valid, clear the pack register.
  - remaining reaches 0 with lane≠0 → FLUSH.
  - remaining reaches 0 with lane=0 → DRAIN.
- **FLUSH**
  - csib=1.
  - When out_valid=0: move the partial word to the output register, with unfilled lanes zero, and set out_valid; lane←0. → DRAIN.
- **DRAIN**
  - csib=1, rdwrb held at 1.
  - When out_valid=0: rdwrb←0, done=1 for one cycle. → IDLE.

Output register behaviour:
- fifo_write_en = out_valid & ~fifo_full. This is the only combinational path from fifo_full.
- out_valid clears on the cycle a write occurs.
- fifo_data holds its value until the write completes.

Other rules:
- start is ignored outside IDLE.
- word_count is latched at start; later changes have no effect.
- Simultaneous events: an 8th-word capture in the same cycle as a FIFO write is legal. Because csib is gated, a capture into lane 7 only occurs when out_valid=0 or when the write drains it that cycle. The new word then loads the output register and out_valid stays 1.

## Timing
- Reset (asynchronous, any state) sets: state=IDLE, icap_csib=1, icap_rdwrb=0, fifo_write_en=0, fifo_data=0, busy=0, done=0, lane=0, remaining=0, out_valid=0.
- Reset mid-read discards all partial data. No FIFO write follows the reset.
- icap_csib and icap_rdwrb are decoded from registered state only.
- Latency:
  - start → csib low: 2 cycles.
  - 8th capture → fifo_write_en: 1 cycle when fifo_full=0.
  - Final write → done: 1 cycle.
- Throughput: one 32-bit word per cycle while icap_busy=0 and the FIFO keeps up.

## Structure
- Shared package icap_pkg: state encoding (IDLE, SETUP, READ, FLUSH, DRAIN), ICAP_WORD_W=32, LANES=8, and the CSIB/RDWRB level constants also used by the write path.
- One sub-module, icap_word_packer: the lane counter, pack register, output register and out_valid/fifo_write_en handshake. The top level holds the FSM and the remaining counter.

## Test plan
- word_count=8 with icap_o=0x0000000N on successive captures, busy low, FIFO never full → one write with fifo_data=0x00000007_…_00000000 (lane N holds N), then done; csib low for exactly 8 cycles.
- word_count=3 with data A,B,C → one write {0…0,C,B,A}: lanes 3–7 zero, then done.
- word_count=16 with fifo_full held high from the first write → csib goes high at lane 7 of the second group; no captures are lost; deasserting fifo_full yields two writes in order.
- icap_busy high on alternate cycles, word_count=8 → only busy-low cycles are captured; single correct write.
- reset_n low midway through word_count=8 → outputs at reset values immediately; no write; a new start reads cleanly.
- start with word_count=0 → done pulse the next cycle; csib never low; no write.
